// File: rtl/vend_sequencer_if.sv
// vend_sequencer_if: strobe/handshake bundle between the vending sequencer and its environment.
// The refill strobe exists only when VEND_REFILL_EN is defined.
interface vend_sequencer_if;
  logic       coin_valid;
  logic [1:0] coin_val;
  logic       sel_valid;
  logic [1:0] sel;
  logic       cancel;
  logic       disp_ready;
`ifdef VEND_REFILL_EN
  logic       refill;
`endif
  logic       disp_valid;
  logic [1:0] disp_prod;
  logic       change_valid;
  logic [1:0] change_amt;
  logic [1:0] credit;
  logic [2:0] sold_out;
  logic       err;
  modport slave (
    input
`ifdef VEND_REFILL_EN
    refill,
`endif
    coin_valid, coin_val, sel_valid, sel, cancel, disp_ready,
    output disp_valid, disp_prod, change_valid, change_amt, credit, sold_out, err
  );
  modport master (
    output
`ifdef VEND_REFILL_EN
    refill,
`endif
    coin_valid, coin_val, sel_valid, sel, cancel, disp_ready,
    input disp_valid, disp_prod, change_valid, change_amt, credit, sold_out, err
  );
endinterface

// File: rtl/vend_sequencer.sv
// vend_sequencer: coin/select/dispense/change vending FSM with per-product stock.
// Optional VEND_REFILL_EN adds a refill strobe that reloads stock while IDLE.
module vend_sequencer #(
  parameter int STOCK_INIT = 3,
  parameter int CHG_HOLD   = 2
) (
  input logic            clk,
  input logic            reset,
  vend_sequencer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CREDIT, DISPENSE, CHANGE} state_t;
  localparam logic [2:0] INIT3 = 3'(STOCK_INIT);
  localparam logic [3:0] HOLD_LAST = 4'(CHG_HOLD - 1);
  state_t          state_q, state_d;
  logic [1:0]      credit_q, credit_d, rem_q, rem_d, prod_q, prod_d, chg_q, chg_d;
  logic [3:0]      hold_q, hold_d;
  logic [2:0][2:0] stock_q, stock_d;
  logic            err_q, err_d;
  logic            coin_ev, sel_ev, sel_ok, front;
  logic [2:0]      sum, sel_stock;
  assign coin_ev   = bus.coin_valid && bus.coin_val != 2'd0;
  assign sel_ev    = bus.sel_valid && bus.sel != 2'd0;
  assign front     = state_q == IDLE || state_q == CREDIT;
  assign sum       = {1'b0, credit_q} + {1'b0, bus.coin_val};
  assign sel_stock = bus.sel == 2'd1 ? stock_q[0] : bus.sel == 2'd2 ? stock_q[1] : stock_q[2];
  assign sel_ok    = sel_stock != 3'd0 && credit_q >= bus.sel;
  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    rem_d    = rem_q;
    prod_d   = prod_q;
    chg_d    = chg_q;
    hold_d   = hold_q;
    stock_d  = stock_q;
    err_d    = 1'b0;
    case (state_q)
      IDLE, CREDIT: begin
        if (bus.cancel) begin
          err_d = sel_ev || coin_ev;
          if (state_q == CREDIT) begin
            state_d  = CHANGE;
            chg_d    = credit_q;
            credit_d = 2'd0;
            hold_d   = 4'd0;
          end
        end else if (sel_ev) begin
          err_d = coin_ev || !sel_ok;
          if (sel_ok) begin
            state_d = DISPENSE;
            prod_d  = bus.sel;
            rem_d   = credit_q - bus.sel;
          end
        end else if (coin_ev) begin
          err_d = sum > 3'd3;
          if (sum <= 3'd3) begin
            credit_d = sum[1:0];
            state_d  = CREDIT;
          end
        end
      end
      DISPENSE: begin
        err_d = coin_ev || sel_ev || bus.cancel;
        if (bus.disp_ready) begin
          for (int i = 0; i < 3; i++)
            if (prod_q == 2'(i + 1) && stock_q[i] != 3'd0) stock_d[i] = stock_q[i] - 3'd1;
          credit_d = 2'd0;
          chg_d    = rem_q;
          hold_d   = 4'd0;
          state_d  = rem_q != 2'd0 ? CHANGE : IDLE;
        end
      end
      CHANGE: begin
        err_d  = coin_ev || sel_ev || bus.cancel;
        hold_d = hold_q == HOLD_LAST ? 4'd0 : hold_q + 4'd1;
        state_d = hold_q == HOLD_LAST ? IDLE : CHANGE;
      end
      default: begin
        state_d  = IDLE;
        credit_d = 2'd0;
        chg_d    = 2'd0;
        hold_d   = 4'd0;
      end
    endcase
`ifdef VEND_REFILL_EN
    if (bus.refill) begin
      if (state_q == IDLE) stock_d = {3{INIT3}};
      else err_d = 1'b1;
    end
`endif
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      credit_q <= 2'd0;
      rem_q    <= 2'd0;
      prod_q   <= 2'd0;
      chg_q    <= 2'd0;
      hold_q   <= 4'd0;
      stock_q  <= {3{INIT3}};
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      rem_q    <= rem_d;
      prod_q   <= prod_d;
      chg_q    <= chg_d;
      hold_q   <= hold_d;
      stock_q  <= stock_d;
      err_q    <= err_d;
    end
  end
  assign bus.disp_valid   = state_q == DISPENSE;
  assign bus.disp_prod    = state_q == DISPENSE ? prod_q : 2'd0;
  assign bus.change_valid = state_q == CHANGE;
  assign bus.change_amt   = state_q == CHANGE ? chg_q : 2'd0;
  assign bus.credit       = credit_q;
  assign bus.err          = err_q;
  assign bus.sold_out     = {stock_q[2] == 3'd0, stock_q[1] == 3'd0, stock_q[0] == 3'd0};
endmodule

// File: tb/tb_vend_sequencer.sv
// tb_vend_sequencer: directed vectors with hand-computed expectations (STOCK_INIT=3, CHG_HOLD=2).
module tb_vend_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  vend_sequencer_if bus();
  vend_sequencer #(.STOCK_INIT(3), .CHG_HOLD(2)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic act(input logic cv, input logic [1:0] c, input logic sv, input logic [1:0] s, input logic cn);
    bus.coin_valid = cv;
    bus.coin_val   = c;
    bus.sel_valid  = sv;
    bus.sel        = s;
    bus.cancel     = cn;
    step();
    bus.coin_valid = 1'b0;
    bus.coin_val   = 2'd0;
    bus.sel_valid  = 1'b0;
    bus.sel        = 2'd0;
    bus.cancel     = 1'b0;
  endtask
  task automatic coin(input logic [1:0] c);
    act(1'b1, c, 1'b0, 2'd0, 1'b0);
  endtask
  task automatic sel(input logic [1:0] s);
    act(1'b0, 2'd0, 1'b1, s, 1'b0);
  endtask
  task automatic cancel();
    act(1'b0, 2'd0, 1'b0, 2'd0, 1'b1);
  endtask
  initial begin
    bus.coin_valid = 1'b0;
    bus.coin_val   = 2'd0;
    bus.sel_valid  = 1'b0;
    bus.sel        = 2'd0;
    bus.cancel     = 1'b0;
    bus.disp_ready = 1'b1;
`ifdef VEND_REFILL_EN
    bus.refill     = 1'b0;
`endif
    step();
    step();
    reset = 1'b0;
    chk("rst_credit", 8'(bus.credit), 8'd0);
    chk("rst_disp", 8'({bus.disp_valid, bus.disp_prod}), 8'd0);
    chk("rst_chg", 8'({bus.change_valid, bus.change_amt}), 8'd0);
    chk("rst_sold", 8'(bus.sold_out), 8'd0);
    chk("rst_err", 8'(bus.err), 8'd0);
    cancel();
    chk("idle_cancel_err", 8'(bus.err), 8'd0);
    chk("idle_cancel_chg", 8'(bus.change_valid), 8'd0);
    coin(2'd0);
    chk("coin0_credit", 8'(bus.credit), 8'd0);
    chk("coin0_err", 8'(bus.err), 8'd0);
    coin(2'd2);
    chk("c2_credit", 8'(bus.credit), 8'd2);
    sel(2'd1);
    chk("s1_disp", 8'({bus.disp_valid, bus.disp_prod}), 8'd5);
    step();
    chk("s1_disp_done", 8'(bus.disp_valid), 8'd0);
    chk("s1_chg", 8'({bus.change_valid, bus.change_amt}), 8'd5);
    chk("s1_credit", 8'(bus.credit), 8'd0);
    step();
    chk("s1_chg_hold", 8'({bus.change_valid, bus.change_amt}), 8'd5);
    step();
    chk("s1_chg_end", 8'({bus.change_valid, bus.change_amt}), 8'd0);
    coin(2'd3);
    chk("c3_credit", 8'(bus.credit), 8'd3);
    coin(2'd1);
    chk("ovf_err", 8'(bus.err), 8'd1);
    chk("ovf_credit", 8'(bus.credit), 8'd3);
    sel(2'd3);
    chk("ovf_err_pulse", 8'(bus.err), 8'd0);
    chk("s3_disp", 8'({bus.disp_valid, bus.disp_prod}), 8'd7);
    step();
    chk("s3_nochg", 8'({bus.disp_valid, bus.change_valid}), 8'd0);
    chk("s3_credit", 8'(bus.credit), 8'd0);
    coin(2'd1);
    sel(2'd2);
    chk("poor_err", 8'(bus.err), 8'd1);
    chk("poor_credit", 8'(bus.credit), 8'd1);
    chk("poor_disp", 8'(bus.disp_valid), 8'd0);
    coin(2'd2);
    chk("c1p2_credit", 8'(bus.credit), 8'd3);
    cancel();
    chk("cancel_chg", 8'({bus.change_valid, bus.change_amt}), 8'd7);
    chk("cancel_credit", 8'(bus.credit), 8'd0);
    step();
    step();
    chk("cancel_end", 8'(bus.change_valid), 8'd0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      coin(2'd1);
      sel(2'd1);
      step();
    end
    chk("sellout", 8'(bus.sold_out), 8'd1);
    coin(2'd3);
    sel(2'd1);
    chk("sellout_err", 8'(bus.err), 8'd1);
    chk("sellout_disp", 8'(bus.disp_valid), 8'd0);
    chk("sellout_credit", 8'(bus.credit), 8'd3);
    cancel();
    step();
    step();
    bus.disp_ready = 1'b0;
    coin(2'd2);
    sel(2'd2);
    chk("stall_disp", 8'({bus.disp_valid, bus.disp_prod}), 8'd6);
    coin(2'd1);
    chk("stall_coin_err", 8'(bus.err), 8'd1);
    chk("stall_credit", 8'(bus.credit), 8'd2);
    cancel();
    chk("stall_cancel_err", 8'(bus.err), 8'd1);
    chk("stall_hold", 8'({bus.disp_valid, bus.disp_prod, bus.change_valid}), 8'd12);
    bus.disp_ready = 1'b1;
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort_state", 8'({bus.disp_valid, bus.change_valid, bus.credit}), 8'd0);
    chk("abort_stock", 8'(bus.sold_out), 8'd0);
    step();
    chk("abort_nochg", 8'(bus.change_valid), 8'd0);
    coin(2'd2);
    act(1'b1, 2'd1, 1'b1, 2'd1, 1'b1);
    chk("prio_chg", 8'({bus.change_valid, bus.change_amt}), 8'd6);
    chk("prio_err", 8'(bus.err), 8'd1);
    chk("prio_disp", 8'(bus.disp_valid), 8'd0);
    chk("prio_credit", 8'(bus.credit), 8'd0);
    step();
    step();
`ifdef VEND_REFILL_EN
    for (int i = 0; i < 3; i++) begin
      coin(2'd3);
      sel(2'd3);
      step();
    end
    chk("sellout3", 8'(bus.sold_out), 8'd4);
    coin(2'd1);
    bus.refill = 1'b1;
    step();
    bus.refill = 1'b0;
    chk("refill_busy_err", 8'(bus.err), 8'd1);
    chk("refill_busy_sold", 8'(bus.sold_out), 8'd4);
    cancel();
    step();
    step();
    bus.refill = 1'b1;
    step();
    bus.refill = 1'b0;
    chk("refill_sold", 8'(bus.sold_out), 8'd0);
    chk("refill_err", 8'(bus.err), 8'd0);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/vend_sequencer.md
VEND_SEQUENCER -- requirements
Module: vend_sequencer

Interface
REQ-001 Parameter STOCK_INIT, 3, initial units per product (1..7), SHALL be the 3-bit stock preload.
REQ-002 Parameter CHG_HOLD, 2, SHALL be the number of cycles change_valid is held (1..15).
REQ-003 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  in  1  SHALL be a synchronous, active-high reset.
REQ-005 coin_valid  in  1  SHALL be a one-cycle coin-insert strobe.
REQ-006 coin_val  in  2  SHALL be the coin value in credit units (1..3); 0 SHALL be ignored.
REQ-007 sel_valid  in  1  SHALL be a one-cycle product-select strobe.
REQ-008 sel  in  2  SHALL be the product code: 1=Pepsi, 2=Coca, 3=RedBull; 0 SHALL be ignored. Price equals the code.
REQ-009 cancel  in  1  SHALL be a one-cycle refund-request strobe.
REQ-010 disp_ready  in  1  SHALL be the dispenser accept signal.
REQ-011 disp_valid  out  1  SHALL be the dispense request.
REQ-012 disp_prod  out  2  SHALL be the product being dispensed; 0 when disp_valid=0.
REQ-013 change_valid  out  1  SHALL indicate that change is being returned.
REQ-014 change_amt  out  2  SHALL be the change amount; 0 when change_valid=0.
REQ-015 credit  out  2  SHALL be the current registered credit (0..3).
REQ-016 sold_out  out  3  SHALL have bit i-1 set when product i stock is 0.
REQ-017 err  out  1  SHALL be a one-cycle pulse for each rejected event.

Function
REQ-018 FSM states: IDLE (credit=0), CREDIT (credit>0), DISPENSE, CHANGE.
REQ-019 Coins are accepted in IDLE/CREDIT only. A coin SHALL add coin_val to credit next cycle, and the state SHALL become CREDIT. If credit+coin_val>3, the coin SHALL be rejected: credit unchanged, err=1.
REQ-020 A select in IDLE/CREDIT SHALL be accepted when sel!=0, stock[sel]>0 and credit>=sel. On acceptance: go to DISPENSE next cycle with disp_prod=sel; remainder credit-sel is latched.
REQ-021 Select with insufficient credit or zero stock SHALL be rejected: err=1, state and credit unchanged.
REQ-022 Same-cycle priority: cancel > sel > coin. Any valid lower-priority strobe dropped because of priority SHALL pulse err.
REQ-023 Cancel in CREDIT SHALL go to CHANGE with change_amt=credit and credit=0. Cancel in IDLE is a no-op with no err.
REQ-024 DISPENSE: disp_valid SHALL be held with disp_prod stable until the first cycle where disp_ready=1. That cycle completes the transfer: stock[disp_prod] decrements and credit clears.
REQ-025 After a transfer: remainder>0 -> CHANGE; remainder=0 -> IDLE. Both take effect next cycle.
REQ-026 CHANGE: change_valid=1 with change_amt stable for exactly CHG_HOLD cycles, then go to IDLE.
REQ-027 In DISPENSE and CHANGE, all coin, select and cancel strobes SHALL be ignored and SHALL pulse err (cancel included).
REQ-028 Stock SHALL never underflow; sold_out SHALL be combinational from the stock registers.
REQ-029 Illegal state encoding SHALL recover to IDLE next cycle with all outputs 0.

Reset
REQ-030 Reset SHALL force, at the next clk edge: IDLE, credit=0, remainder=0, all stock=STOCK_INIT, disp_valid=0, disp_prod=0, change_valid=0, change_amt=0, err=0, hold counter=0.
REQ-031 Reset asserted mid-DISPENSE or mid-CHANGE SHALL abort the operation with no stock decrement and no change output.

Configuration
REQ-032 Macro VEND_REFILL_EN SHALL add the input refill (1 bit).
REQ-033 With VEND_REFILL_EN defined: refill=1 in IDLE reloads all stock to STOCK_INIT next cycle; refill=1 in any other state SHALL pulse err and be ignored.
REQ-034 Without VEND_REFILL_EN: the refill port SHALL NOT exist, and stock SHALL reload only on reset.

Verification
REQ-035 coin 2, sel 1, disp_ready=1 one cycle later -> disp_valid/disp_prod=1 for 1 cycle, then change_valid=1 with change_amt=1 for CHG_HOLD cycles, then IDLE, credit=0.
REQ-036 coin 3, then coin 1 -> second coin rejected, err pulse, credit stays 3; sel 3 -> dispense product 3, no change.
REQ-037 credit 1, sel 2 -> err pulse, stays CREDIT with credit=1; cancel -> change_amt=1, credit=0.
REQ-038 Dispense product 1 STOCK_INIT times -> sold_out[0]=1; next sel 1 with credit 3 -> err, no dispense.
REQ-039 disp_ready held 0 for 5 cycles in DISPENSE while coin and cancel are pulsed -> disp_valid held, err pulses, credit unchanged; reset in cycle 3 -> IDLE, stock unchanged.
REQ-040 Same-cycle cancel+sel+coin with credit 2 -> refund 2, err pulse, no dispense; with VEND_REFILL_EN, refill in IDLE after a sellout -> sold_out=000.
